// File: rtl/tpum_bnn_seq.sv
// APB-programmed XNOR-popcount sequencer: streams weight/input rows from xbox and writes packed results back.
// Optional macro TPUM_THRESH_EN adds the THRESH register (index 9) and sign-activated result fields.
module tpum_bnn_seq #(
  parameter int ROW_W  = 1024,
  parameter int ADDR_W = 14,
  parameter int RES_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [11:0]       paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              xb_rd_req,
  input  logic              xb_rd_valid,
  input  logic [ROW_W-1:0]  xb_rdata,
  output logic              xb_wr_req,
  input  logic              xb_wr_ack,
  output logic [ADDR_W-1:0] xb_addr,
  output logic [ROW_W-1:0]  xb_wdata,
  output logic              irq
);
  localparam int NFLD  = ROW_W / RES_W;
  localparam int NWORD = ROW_W / 32;

  typedef enum logic [6:0] {
    S_IDLE  = 7'b0000001,
    S_LD_W  = 7'b0000010,
    S_LD_X  = 7'b0000100,
    S_CALC  = 7'b0001000,
    S_ST_RA = 7'b0010000,
    S_DONE  = 7'b0100000,
    S_ERR   = 7'b1000000
  } state_t;

  state_t           state;
  logic [31:0]      dim_a, dim_b, base_a, base_b, base_c;
  logic [31:0]      w_cnt, x_cnt;
  logic             busy, done, err, irq_en;
  logic [ROW_W-1:0] r1, r2, ra;
`ifdef TPUM_THRESH_EN
  logic [RES_W-1:0] thresh;
`endif

  logic [9:0]  idx;
  logic        unused_paddr;
  logic        acc, locked, unmapped, slverr, wr_ok, start_req, abort_req;
  logic [31:0] rd_val;
  logic [RES_W-1:0] pop, field;

  function automatic logic [RES_W-1:0] xnor_pop(input logic [ROW_W-1:0] a,
                                                input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0] m;
    logic [RES_W-1:0] c;
    m = ~(a ^ b);
    c = '0;
    for (int i = 0; i < ROW_W; i++) c = c + RES_W'(m[i]);
    return c;
  endfunction

  assign idx          = paddr[11:2];
  assign unused_paddr = ^paddr[1:0];

  always_comb begin
    pop = xnor_pop(r1, r2);
`ifdef TPUM_THRESH_EN
    field = (pop >= thresh) ? RES_W'(1) : '0;
`else
    field = pop;
`endif
  end

  // Read mux and address decode; RA words live at 16.. and everything else unlisted is an error.
  always_comb begin
    rd_val   = '0;
    unmapped = 1'b0;
    case (idx)
      10'd0: rd_val = dim_a;
      10'd1: rd_val = dim_b;
      10'd2: rd_val = base_a;
      10'd3: rd_val = base_b;
      10'd4: rd_val = base_c;
      10'd5: rd_val = '0;
      10'd6: rd_val = {29'd0, err, done, busy};
      10'd7: rd_val = {25'd0, state};
      10'd8: rd_val = {31'd0, irq_en};
`ifdef TPUM_THRESH_EN
      10'd9: rd_val = 32'(thresh);
`endif
      default: begin
        unmapped = 1'b1;
        for (int k = 0; k < NWORD; k++) begin
          if (idx == 10'(16 + k)) begin
            rd_val   = ra[k*32 +: 32];
            unmapped = 1'b0;
          end
        end
      end
    endcase
  end

  assign acc       = psel & penable & ~pready;
  assign locked    = pwrite & busy & (idx <= 10'd4);
  assign slverr    = unmapped | locked;
  assign wr_ok     = acc & pwrite & ~slverr;
  assign abort_req = wr_ok & (idx == 10'd5) & pwdata[1];
  assign start_req = wr_ok & (idx == 10'd5) & pwdata[0] & ~pwdata[1];
  assign xb_wdata  = ra;
  assign irq       = done & irq_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      xb_rd_req <= 1'b0;
      xb_wr_req <= 1'b0;
      xb_addr   <= '0;
      state     <= S_IDLE;
      dim_a     <= '0;
      dim_b     <= '0;
      base_a    <= '0;
      base_b    <= '0;
      base_c    <= '0;
      w_cnt     <= '0;
      x_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      irq_en    <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      ra        <= '0;
`ifdef TPUM_THRESH_EN
      thresh    <= '0;
`endif
    end else begin
      pready  <= acc;
      pslverr <= acc & slverr;
      prdata  <= (acc & ~pwrite & ~slverr) ? rd_val : '0;

      if (wr_ok) begin
        case (idx)
          10'd0: dim_a  <= pwdata;
          10'd1: dim_b  <= pwdata;
          10'd2: base_a <= pwdata;
          10'd3: base_b <= pwdata;
          10'd4: base_c <= pwdata;
          10'd6: begin
            done <= done & ~pwdata[1];
            err  <= err & ~pwdata[2];
          end
          10'd8: irq_en <= pwdata[0];
`ifdef TPUM_THRESH_EN
          10'd9: thresh <= pwdata[RES_W-1:0];
`endif
          default: ;
        endcase
      end

      // FSM updates come after the APB writes so an FSM set of done/err beats a same-cycle W1C.
      if (abort_req && state != S_IDLE) begin
        state     <= S_IDLE;
        xb_rd_req <= 1'b0;
        xb_wr_req <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        err       <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req) begin
              if (dim_a == 32'd0 || dim_b == 32'd0 || dim_a > 32'(NFLD)) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= S_ERR;
              end else begin
                w_cnt     <= '0;
                ra        <= '0;
                busy      <= 1'b1;
                xb_rd_req <= 1'b1;
                xb_addr   <= ADDR_W'(base_b);
                state     <= S_LD_W;
              end
            end
          end
          S_LD_W: begin
            if (xb_rd_valid) begin
              r2      <= xb_rdata;
              x_cnt   <= '0;
              xb_addr <= ADDR_W'(base_a);
              state   <= S_LD_X;
            end
          end
          S_LD_X: begin
            if (xb_rd_valid) begin
              r1        <= xb_rdata;
              xb_rd_req <= 1'b0;
              state     <= S_CALC;
            end
          end
          S_CALC: begin
            for (int k = 0; k < NFLD; k++) begin
              if (x_cnt == 32'(k)) ra[k*RES_W +: RES_W] <= field;
            end
            x_cnt <= x_cnt + 32'd1;
            if (x_cnt + 32'd1 < dim_a) begin
              xb_rd_req <= 1'b1;
              xb_addr   <= ADDR_W'(base_a + x_cnt + 32'd1);
              state     <= S_LD_X;
            end else begin
              xb_wr_req <= 1'b1;
              xb_addr   <= ADDR_W'(base_c + w_cnt);
              state     <= S_ST_RA;
            end
          end
          S_ST_RA: begin
            if (xb_wr_ack) begin
              xb_wr_req <= 1'b0;
              w_cnt     <= w_cnt + 32'd1;
              ra        <= '0;
              if (w_cnt + 32'd1 < dim_b) begin
                xb_rd_req <= 1'b1;
                xb_addr   <= ADDR_W'(base_b + w_cnt + 32'd1);
                state     <= S_LD_W;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          S_ERR:   state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tpum_bnn_seq.sv
// Bench for tpum_bnn_seq: APB driver, variable-latency xbox memory model and read/write scoreboard.
`timescale 1ns/1ps
module tb_tpum_bnn_seq;
  localparam int ROW_W  = 1024;
  localparam int ADDR_W = 14;
  localparam int RES_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef struct { addr_t addr; row_t data; } wr_t;

  logic        clk, rst_n, psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, xb_rd_req, xb_rd_valid, xb_wr_req, xb_wr_ack, irq;
  row_t        xb_rdata, xb_wdata;
  addr_t       xb_addr;

  tpum_bnn_seq #(.ROW_W(ROW_W), .ADDR_W(ADDR_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .xb_rd_req(xb_rd_req), .xb_rd_valid(xb_rd_valid), .xb_rdata(xb_rdata),
    .xb_wr_req(xb_wr_req), .xb_wr_ack(xb_wr_ack), .xb_addr(xb_addr),
    .xb_wdata(xb_wdata), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  row_t  mem [addr_t];
  addr_t exp_rd[$];
  wr_t   exp_wr[$];
  int    lat_rand = 0, lat_fixed = 1, thr_val = 0;
  int    rd_seen = 0, wr_seen = 0, overlap_err = 0, stab_err = 0;
  row_t  ones = '1;

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < ROW_W/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [RES_W-1:0] model_field(input row_t w, input row_t x);
    int pc;
    pc = $countones(~(w ^ x));
`ifdef TPUM_THRESH_EN
    return (pc >= thr_val) ? RES_W'(1) : RES_W'(0);
`else
    return RES_W'(pc);
`endif
  endfunction

  // xbox memory: one request at a time, answered after a fixed or random latency.
  initial begin : xbox_model
    int    cnt;
    bit    kind;
    addr_t a_l, ea;
    wr_t   ew;
    cnt = 0; kind = 0; a_l = '0;
    xb_rd_valid = 1'b0; xb_wr_ack = 1'b0; xb_rdata = '0;
    forever begin
      @(negedge clk);
      xb_rd_valid = 1'b0;
      xb_wr_ack   = 1'b0;
      if (xb_rd_req && xb_wr_req) overlap_err++;
      if (cnt == 0) begin
        if (xb_rd_req || xb_wr_req) begin
          kind = xb_wr_req;
          a_l  = xb_addr;
          cnt  = lat_rand ? int'($urandom_range(1, 8)) : lat_fixed;
          checks++;
          if (!kind) begin
            rd_seen++;
            if (exp_rd.size() == 0) begin
              errors++;
              $display("FAIL rd_addr unexpected read got=%h", a_l);
            end else begin
              ea = exp_rd.pop_front();
              if (a_l !== ea) begin
                errors++;
                $display("FAIL rd_addr got=%h want=%h", a_l, ea);
              end
            end
          end else begin
            wr_seen++;
            if (exp_wr.size() == 0) begin
              errors++;
              $display("FAIL wr unexpected write got_addr=%h", a_l);
            end else begin
              ew = exp_wr.pop_front();
              if (a_l !== ew.addr || xb_wdata !== ew.data) begin
                errors++;
                $display("FAIL wr addr=%h want_addr=%h data_lo=%h want_lo=%h",
                         a_l, ew.addr, xb_wdata[63:0], ew.data[63:0]);
              end
            end
          end
        end
      end else if ((kind ? xb_wr_req : xb_rd_req) && xb_addr !== a_l) begin
        stab_err++;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          if (kind) xb_wr_ack = 1'b1;
          else begin
            xb_rd_valid = 1'b1;
            xb_rdata    = mem.exists(a_l) ? mem[a_l] : '0;
          end
        end
      end
    end
  end

  task automatic apb_xfer(input bit wr, input int index, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 12'(index * 4); pwdata = wdata;
    @(negedge clk);
    penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pready) break;
    end
    if (!pready) begin
      checks++; errors++;
      $display("FAIL apb_timeout index=%0d pready=%b want=1", index, pready);
    end
    rdata = prdata;
    err   = pslverr;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input int index, input logic [31:0] data, output logic err);
    logic [31:0] d;
    apb_xfer(1'b1, index, data, d, err);
  endtask

  task automatic apb_rd(input int index, output logic [31:0] data, output logic err);
    apb_xfer(1'b0, index, 32'd0, data, err);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    logic e;
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      apb_rd(6, s, e);
      if (!s[0]) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout busy=1 want=0", tag); end
  endtask

  task automatic setup(input int da, input int db, input int ba, input int bb, input int bc);
    logic e;
    apb_wr(0, 32'(da), e);
    apb_wr(1, 32'(db), e);
    apb_wr(2, 32'(ba), e);
    apb_wr(3, 32'(bb), e);
    apb_wr(4, 32'(bc), e);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, xb_rd_req, xb_wr_req, xb_addr, irq} !== '0 || xb_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs prdata=%h pready=%b pslverr=%b rd=%b wr=%b addr=%h irq=%b want all 0",
               prdata, pready, pslverr, xb_rd_req, xb_wr_req, xb_addr, irq);
    end
    rst_n = 1'b1;
    apb_rd(7, d, e);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL reset_state got=%h want=1", d); end
    apb_rd(6, d, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_status got=%h want=0", d); end
    apb_rd(0, d, e);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_dim_a got=%h want=0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic e;
    wr_t w;
    mem[addr_t'(14'h100)] = '1;
    mem[addr_t'(14'h200)] = '1;
    mem[addr_t'(14'h201)] = '0;
    lat_rand = 0; lat_fixed = 1;
    setup(2, 1, 32'h200, 32'h100, 32'h300);
    apb_wr(8, 32'd1, e);
    exp_rd.push_back(addr_t'(14'h100));
    exp_rd.push_back(addr_t'(14'h200));
    exp_rd.push_back(addr_t'(14'h201));
    w.addr = addr_t'(14'h300);
    w.data = '0;
`ifdef TPUM_THRESH_EN
    w.data[0 +: RES_W]     = RES_W'(1);
    w.data[RES_W +: RES_W] = RES_W'(1);
`else
    w.data[0 +: RES_W]     = RES_W'(1024);
    w.data[RES_W +: RES_W] = RES_W'(0);
`endif
    exp_wr.push_back(w);
    apb_wr(5, 32'd1, e);
    wait_idle("basic");
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL basic_pending rd_left=%0d wr_left=%0d want 0", exp_rd.size(), exp_wr.size());
    end
    apb_rd(6, d, e);
    checks++;
    if (d !== 32'h2) begin errors++; $display("FAIL basic_status got=%h want=2", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b want=1", irq); end
    apb_wr(6, 32'h2, e);
    apb_rd(6, d, e);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL basic_w1c status=%h irq=%b want 0 0", d, irq);
    end
  endtask

  task automatic test_wrap();
    logic e;
    row_t wr_row[2];
    row_t x_row[3];
    wr_t w;
    int wr0, ov0, st0;
    for (int i = 0; i < 2; i++) begin
      wr_row[i] = rand_row();
      mem[addr_t'(32'h10 + i)] = wr_row[i];
    end
    for (int i = 0; i < 3; i++) begin
      x_row[i] = rand_row();
      mem[addr_t'(32'h3FFF + i)] = x_row[i];
    end
    for (int j = 0; j < 2; j++) begin
      exp_rd.push_back(addr_t'(32'h10 + j));
      for (int i = 0; i < 3; i++) exp_rd.push_back(addr_t'(32'h3FFF + i));
      w.addr = addr_t'(32'h50 + j);
      w.data = '0;
      for (int i = 0; i < 3; i++) w.data[i*RES_W +: RES_W] = model_field(wr_row[j], x_row[i]);
      exp_wr.push_back(w);
    end
    wr0 = wr_seen; ov0 = overlap_err; st0 = stab_err;
    lat_rand = 1;
    setup(3, 2, 32'h3FFF, 32'h10, 32'h50);
    apb_wr(5, 32'd1, e);
    wait_idle("wrap");
    lat_rand = 0;
    checks++;
    if (wr_seen - wr0 != 2 || exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL wrap_counts writes=%0d want=2 rd_left=%0d wr_left=%0d",
               wr_seen - wr0, exp_rd.size(), exp_wr.size());
    end
    checks++;
    if (overlap_err != ov0 || stab_err != st0) begin
      errors++;
      $display("FAIL wrap_handshake overlap=%0d addr_changes=%0d want 0 0",
               overlap_err - ov0, stab_err - st0);
    end
    apb_wr(6, 32'h2, e);
  endtask

  task automatic test_dim_err();
    logic [31:0] d;
    logic e;
    int da[3] = '{0, 65, 2};
    int db[3] = '{1, 1, 0};
    int req0;
    for (int c = 0; c < 3; c++) begin
      apb_wr(0, 32'(da[c]), e);
      apb_wr(1, 32'(db[c]), e);
      req0 = rd_seen + wr_seen;
      apb_wr(5, 32'd1, e);
      apb_rd(6, d, e);
      checks++;
      if (d !== 32'h4) begin errors++; $display("FAIL dim_err_status case=%0d got=%h want=4", c, d); end
      checks++;
      if (rd_seen + wr_seen != req0) begin
        errors++;
        $display("FAIL dim_err_requests case=%0d got=%0d want=0", c, rd_seen + wr_seen - req0);
      end
      apb_wr(6, 32'h4, e);
      apb_rd(6, d, e);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL dim_err_w1c case=%0d got=%h want=0", c, d); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic e;
    row_t x0;
    bit seen;
    logic [31:0] want;
    x0 = rand_row();
    mem[addr_t'(14'h20)] = '1;
    mem[addr_t'(14'h30)] = x0;
    mem[addr_t'(14'h31)] = '1;
    lat_rand = 0; lat_fixed = 8;
    setup(2, 1, 32'h30, 32'h20, 32'h40);
    exp_rd.push_back(addr_t'(14'h20));
    exp_rd.push_back(addr_t'(14'h30));
    exp_rd.push_back(addr_t'(14'h31));
    apb_wr(5, 32'd1, e);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (xb_rd_req && xb_addr == addr_t'(14'h31)) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL abort_reach_ld_x seen=0 want=1"); end
    apb_wr(5, 32'h2, e);
    checks++;
    if (xb_rd_req !== 1'b0 || xb_wr_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_req_drop rd=%b wr=%b want 0 0", xb_rd_req, xb_wr_req);
    end
    apb_rd(6, d, e);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL abort_status got=%h want=4", d); end
    repeat (12) @(negedge clk);
    apb_rd(7, d, e);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL abort_state got=%h want=1", d); end
    want = {16'd0, model_field(ones, x0)};
    apb_rd(16, d, e);
    checks++;
    if (d !== want) begin errors++; $display("FAIL abort_ra_word0 got=%h want=%h", d, want); end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL abort_pending rd_left=%0d wr_left=%0d want 0", exp_rd.size(), exp_wr.size());
    end
    apb_wr(6, 32'h4, e);
  endtask

  task automatic test_apb_err();
    logic [31:0] d;
    logic e;
    wr_t w;
    row_t x0;
    x0 = rand_row();
    mem[addr_t'(14'h30)] = x0;
    lat_rand = 0; lat_fixed = 8;
    setup(2, 1, 32'h30, 32'h20, 32'h40);
    exp_rd.push_back(addr_t'(14'h20));
    exp_rd.push_back(addr_t'(14'h30));
    exp_rd.push_back(addr_t'(14'h31));
    w.addr = addr_t'(14'h40);
    w.data = '0;
    w.data[0 +: RES_W]     = model_field(ones, x0);
    w.data[RES_W +: RES_W] = model_field(ones, ones);
    exp_wr.push_back(w);
    apb_wr(5, 32'd1, e);
    apb_wr(2, 32'h123, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL busy_write_err got=%b want=1", e); end
    apb_rd(2, d, e);
    checks++;
    if (d !== 32'h30 || e !== 1'b0) begin
      errors++;
      $display("FAIL busy_write_dropped base_a=%h err=%b want 30 0", d, e);
    end
    apb_wr(5, 32'd1, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL busy_start_err got=%b want=0", e); end
    apb_rd(200, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read err=%b data=%h want 1 0", e, d);
    end
    wait_idle("apb_err");
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL apb_err_pending rd_left=%0d wr_left=%0d want 0", exp_rd.size(), exp_wr.size());
    end
    apb_wr(6, 32'h2, e);
`ifndef TPUM_THRESH_EN
    apb_wr(9, 32'd5, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL thresh_unmapped err=%b want=1", e); end
`endif
  endtask

`ifdef TPUM_THRESH_EN
  task automatic test_thresh();
    logic [31:0] d;
    logic e;
    row_t x0, x1;
    wr_t w;
    for (int i = 0; i < ROW_W; i++) begin
      x0[i] = (i < 700);
      x1[i] = (i < 500);
    end
    mem[addr_t'(14'h60)] = '1;
    mem[addr_t'(14'h61)] = x0;
    mem[addr_t'(14'h62)] = x1;
    lat_fixed = 2;
    thr_val = 600;
    apb_wr(9, 32'd600, e);
    apb_rd(9, d, e);
    checks++;
    if (d !== 32'd600 || e !== 1'b0) begin errors++; $display("FAIL thresh_read got=%0d err=%b want 600 0", d, e); end
    setup(2, 1, 32'h61, 32'h60, 32'h70);
    exp_rd.push_back(addr_t'(14'h60));
    exp_rd.push_back(addr_t'(14'h61));
    exp_rd.push_back(addr_t'(14'h62));
    w.addr = addr_t'(14'h70);
    w.data = '0;
    w.data[0 +: RES_W]     = RES_W'(1);
    w.data[RES_W +: RES_W] = RES_W'(0);
    exp_wr.push_back(w);
    apb_wr(5, 32'd1, e);
    wait_idle("thresh");
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL thresh_pending rd_left=%0d wr_left=%0d want 0", exp_rd.size(), exp_wr.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_dim_err();
    test_abort();
    test_apb_err();
`ifdef TPUM_THRESH_EN
    test_thresh();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tpum_bnn_seq.md
Name: tpum_bnn_seq

Overview:
Parametrised successor of the triple-PUM controller. It is an APB-programmed sequencer that streams weight rows (R2) and input rows (R1) from the xbox memory and computes XNOR-popcount for each (input, weight) pair. It packs the per-pair counts into RA and writes RA back to xbox, one row per weight. It sits between the RISC APB fabric and the xbox array, with a proper variable-latency memory handshake.

Parameters:
ROW_W, 1024, xbox row width in bits (multiple of 32, power of 2, 64..4096)
ADDR_W, 14, xbox row address width
RES_W, 16, width of one packed result field; RES_W >= clog2(ROW_W)+1; RA holds ROW_W/RES_W fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write
paddr  in  12  APB byte address; word index = paddr[11:2]
pwdata  in  32  APB write data
prdata  out  32  APB read data
pready  out  1  APB ready
pslverr  out  1  APB error
xb_rd_req  out  1  xbox read request, held until xb_rd_valid
xb_rd_valid  in  1  read data valid, single-cycle pulse
xb_rdata  in  ROW_W  read data
xb_wr_req  out  1  xbox write request, held until xb_wr_ack
xb_wr_ack  in  1  write accepted, single-cycle pulse
xb_addr  out  ADDR_W  row address for the current request
xb_wdata  out  ROW_W  RA contents; valid while xb_wr_req=1
irq  out  1  level interrupt = STATUS.done & IRQ_EN[0]

Behaviour:
- Reset: prdata=0, pready=0, pslverr=0, xb_rd_req=0, xb_wr_req=0, xb_addr=0, xb_wdata=0, irq=0. All registers are 0 and the FSM is in IDLE.
- APB: one wait state. pready is registered and equals psel&penable of the previous cycle, then drops. The access completes on the second access cycle. prdata is registered alongside pready.
- APB errors: pslverr=1 with pready for an unmapped index, and for writes to DIM_A/DIM_B/BASE_* while busy; such writes are dropped.
- Register map (word index):
  - 0 DIM_A: input rows, 1..ROW_W/RES_W
  - 1 DIM_B: weight rows, >=1
  - 2 BASE_A, 3 BASE_B, 4 BASE_C: xbox bases
  - 5 CTRL: bit0 start, bit1 abort; write-only pulses that read as 0
  - 6 STATUS: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C)
  - 7 STATE: RO, one-hot FSM
  - 8 IRQ_EN
  - 9 THRESH (macro only)
  - 16..16+ROW_W/32-1: RA words, RO
- FSM states: IDLE, LD_W, LD_X, CALC, ST_RA, DONE, ERR.
- IDLE: on CTRL.start, if DIM_A==0, DIM_B==0 or DIM_A>ROW_W/RES_W, go to ERR (set err, clear busy). Otherwise clear w_cnt and RA, set busy, go to LD_W.
- LD_W: xb_rd_req=1, xb_addr=BASE_B+w_cnt (truncated to ADDR_W). On xb_rd_valid, capture R2, clear x_cnt, go to LD_X.
- LD_X: xb_rd_req=1, xb_addr=BASE_A+x_cnt. On xb_rd_valid, capture R1, go to CALC.
- CALC (exactly 1 cycle): RA field[x_cnt] = popcount(~(R1^R2)), zero-extended to RES_W; increment x_cnt. If x_cnt+1<DIM_A go to LD_X, else go to ST_RA.
- ST_RA: xb_wr_req=1, xb_addr=BASE_C+w_cnt, xb_wdata=RA. On xb_wr_ack, increment w_cnt and clear RA. If w_cnt+1<DIM_B go to LD_W, else go to DONE.
- DONE: set STATUS.done, clear busy, go to IDLE next cycle.
- ERR: go to IDLE next cycle.
- Request rules: xb_rd_req and xb_wr_req are never asserted together. xb_addr is stable while a request is held. A valid or ack arriving with no request pending is ignored.
- Field packing: field k occupies RA[k*RES_W +: RES_W]. Unused fields are 0.
- Address arithmetic wraps modulo 2^ADDR_W with no error.
- Abort: CTRL.abort in any non-IDLE state drops requests next cycle and returns to IDLE with busy=0, done=0, err=1. An in-flight valid/ack arriving afterwards is ignored. Start and abort written together: abort wins.
- Start while busy is ignored and does not set pslverr.
- Done W1C in the same cycle the FSM sets done: the set wins.
- Reset mid-operation returns everything to reset values immediately.

Optional Feature:
TPUM_THRESH_EN.
- Defined: register 9 THRESH (RES_W bits, reset 0) is added. In CALC the field = (popcount >= THRESH) ? 1 : 0, i.e. sign activation.
- Undefined: index 9 is unmapped (pslverr), and the field is the raw popcount.

Test Plan:
1. ROW_W=1024, DIM_A=2, DIM_B=1, memory returns R2=all-ones and R1 rows all-ones / all-zeros, start -> one write to BASE_C with field0=1024, field1=0, then done=1 and irq=1 (IRQ_EN=1).
2. DIM_A=3, DIM_B=2, BASE_A=0x3FFF, memory valid latency randomised 1..8 cycles -> read addresses 0x3FFF, 0x0000, 0x0001 per weight (wrap), exactly 2 writes at BASE_C and BASE_C+1, and no overlapping requests.
3. DIM_A=0 then start -> STATUS=0b100, no xbox request, W1C 0x4 clears err.
4. Abort written while in LD_X with a pending read, and valid arrives 2 cycles later -> xb_rd_req=0 the next cycle, state=IDLE, err=1, RA unchanged by the late data.
5. Write BASE_A while busy -> pslverr=1 and the value is unchanged; read index 200 -> pslverr=1 and prdata=0.
6. TPUM_THRESH_EN defined, THRESH=600, popcounts 700 and 500 -> fields 1 and 0; macro undefined, write to index 9 -> pslverr=1.
